bcd_updown_counter: RTL and testbench

- Parametrised multi-digit BCD up/down counter; the sequential successor to the team's 4-bit BCD code-conversion blocks.
- Holds DIGITS packed BCD digits, each 0..9. Supports synchronous load, count enable, direction select, wrap with carry/borrow pulse, and rejection of illegal (1010..1111) load digits.
- Drives lab seven-segment and display datapaths. Also serves as the stimulus/reference counter for later code-converter labs.

---
 rtl/bcd_updown_counter.sv | 59 +++++
 tb/tb_bcd_updown_counter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: DIGITS-wide packed BCD up/down counter with load, wrap pulse and illegal-load rejection.
// Optional BCD_EXCESS3_OUT_EN adds a registered Excess-3 copy of q on port xs3.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   d,
`ifdef BCD_EXCESS3_OUT_EN
    output logic [4*DIGITS-1:0]   xs3,
`endif
    output logic [4*DIGITS-1:0]   q,
    output logic                  co,
    output logic                  err
);
    logic [DIGITS:0]       c;
    logic [DIGITS-1:0]     ok;
    logic [4*DIGITS-1:0]   nxt;
    logic [4*DIGITS-1:0]   q_d;
    logic                  ld_ok;
    assign c[0] = 1'b1;
    // c[i] means every lower digit is at its wrap value, so digit i steps this cycle
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        logic [3:0] dig;
        assign dig = q[4*i +: 4];
        assign ok[i] = d[4*i +: 4] <= 4'd9;
        assign nxt[4*i +: 4] = !c[i] ? dig : up ? (dig == 4'd9 ? 4'd0 : dig + 4'd1)
                                                : (dig == 4'd0 ? 4'd9 : dig - 4'd1);
        assign c[i+1] = c[i] & (up ? dig == 4'd9 : dig == 4'd0);
    end
    assign ld_ok = &ok;
    assign q_d   = load ? (ld_ok ? d : q) : en ? nxt : q;
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            co  <= 1'b0;
            err <= 1'b0;
        end else begin
            q   <= q_d;
            co  <= !load && en && c[DIGITS];
            err <= load && !ld_ok;
        end
    end
`ifdef BCD_EXCESS3_OUT_EN
    logic [4*DIGITS-1:0] x_d;
    for (genvar j = 0; j < DIGITS; j++) begin : g_xs3
        assign x_d[4*j +: 4] = q_d[4*j +: 4] + 4'd3;
    end
    always_ff @(posedge clk) begin
        if (rst)
            xs3 <= {DIGITS{4'd3}};
        else
            xs3 <= x_d;
    end
`endif
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: vector table, corner sequences and random run against an integer model (DIGITS=2).
module tb_bcd_updown_counter;
    localparam int DIGITS = 2;
    logic clk = 0, rst, en, up, load;
    logic [7:0] d, q;
    logic co, err;
    int checks = 0, failures = 0;
`ifdef BCD_EXCESS3_OUT_EN
    logic [7:0] xs3;
`endif

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
`ifdef BCD_EXCESS3_OUT_EN
        .xs3(xs3),
`endif
        .q(q), .co(co), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, l, e, u;
        logic [7:0] d, q;
        logic co, err;
    } vec_t;
    vec_t v[25];

    function automatic logic [7:0] enc(int val);
        enc = {4'(val / 10), 4'(val % 10)};
    endfunction

    function automatic bit legal(logic [7:0] x);
        legal = (x[7:4] <= 9) && (x[3:0] <= 9);
    endfunction

    function automatic int dec(logic [7:0] x);
        dec = int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, l, e, u, input logic [7:0] dd,
                         input logic [7:0] eq, input logic eco, eerr, input string tag);
        rst = r; load = l; en = e; up = u; d = dd;
        @(posedge clk);
        #1;
        check({tag, ".q"}, 32'(q), 32'(eq));
        check({tag, ".co"}, 32'(co), 32'(eco));
        check({tag, ".err"}, 32'(err), 32'(eerr));
`ifdef BCD_EXCESS3_OUT_EN
        check({tag, ".xs3"}, 32'(xs3), 32'({eq[7:4] + 4'd3, eq[3:0] + 4'd3}));
`endif
    endtask

    initial begin
        int mq, cos;
        bit mco, merr;
        //        r  l  e  u  d      q      co err
        v[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 0, 0};
        v[1]  = '{0, 1, 0, 0, 8'h35, 8'h35, 0, 0};
        v[2]  = '{0, 0, 1, 1, 8'h00, 8'h36, 0, 0};
        v[3]  = '{0, 0, 1, 1, 8'h00, 8'h37, 0, 0};
        v[4]  = '{1, 1, 1, 1, 8'h55, 8'h00, 0, 0};
        v[5]  = '{0, 1, 0, 0, 8'h98, 8'h98, 0, 0};
        v[6]  = '{0, 0, 1, 1, 8'h00, 8'h99, 0, 0};
        v[7]  = '{0, 0, 1, 1, 8'h00, 8'h00, 1, 0};
        v[8]  = '{0, 0, 1, 1, 8'h00, 8'h01, 0, 0};
        v[9]  = '{0, 1, 0, 0, 8'h01, 8'h01, 0, 0};
        v[10] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        v[11] = '{0, 0, 1, 0, 8'h00, 8'h99, 1, 0};
        v[12] = '{0, 0, 1, 0, 8'h00, 8'h98, 0, 0};
        v[13] = '{0, 1, 0, 0, 8'h09, 8'h09, 0, 0};
        v[14] = '{0, 0, 1, 1, 8'h00, 8'h10, 0, 0};
        v[15] = '{0, 0, 1, 0, 8'h00, 8'h09, 0, 0};
        v[16] = '{0, 1, 0, 0, 8'h42, 8'h42, 0, 0};
        v[17] = '{0, 1, 0, 0, 8'h4A, 8'h42, 0, 1};
        v[18] = '{0, 0, 0, 0, 8'h00, 8'h42, 0, 0};
        v[19] = '{0, 1, 1, 1, 8'h27, 8'h27, 0, 0};
        v[20] = '{0, 0, 0, 1, 8'h00, 8'h27, 0, 0};
        v[21] = '{0, 1, 1, 0, 8'hA0, 8'h27, 0, 1};
        v[22] = '{0, 1, 1, 1, 8'hF9, 8'h27, 0, 1};
        v[23] = '{0, 0, 1, 1, 8'h00, 8'h28, 0, 0};
        v[24] = '{1, 0, 1, 1, 8'h00, 8'h00, 0, 0};
        rst = 1; load = 0; en = 0; up = 0; d = '0;
        for (int i = 0; i < 25; i++)
            cycle(v[i].r, v[i].l, v[i].e, v[i].u, v[i].d, v[i].q, v[i].co, v[i].err,
                  $sformatf("vec%0d", i));

        // full sweep from 00: every value in order, exactly one carry
        cos = 0;
        for (int i = 1; i <= 100; i++) begin
            rst = 0; load = 0; en = 1; up = 1; d = '0;
            @(posedge clk);
            #1;
            check($sformatf("sweep%0d.q", i), 32'(q), 32'(enc(i % 100)));
            if (co) cos++;
        end
        check("sweep.co_count", 32'(cos), 32'd1);

        // random traffic against an integer model
        mq = dec(q);
        for (int i = 0; i < 400; i++) begin
            logic r, l, e, u;
            logic [7:0] dd;
            r = ($urandom_range(0, 31) == 0);
            l = ($urandom_range(0, 5) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            dd = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : enc(int'($urandom_range(0, 99)));
            mco = 0; merr = 0;
            if (r) mq = 0;
            else if (l) begin
                if (legal(dd)) mq = dec(dd);
                else merr = 1;
            end else if (e) begin
                mco = u ? (mq == 99) : (mq == 0);
                mq = u ? (mq + 1) % 100 : (mq + 99) % 100;
            end
            cycle(r, l, e, u, dd, enc(mq), mco, merr, $sformatf("rnd%0d", i));
            if (co && err) check("rnd.co_err_exclusive", 32'd1, 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
